// File: rtl/vx_vector_slicer.sv
// rtl/vx_vector_slicer.sv - slices a captured vector op into NUM_THREADS-lane beats
`ifndef VLEN_ARCH
`define VLEN_ARCH 256
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

module vx_vector_slicer #(
  parameter int VLEN        = `VLEN_ARCH,
  parameter int NUM_THREADS = `NUM_THREADS,
  parameter int XLEN        = `XLEN,
  parameter int NW_WIDTH    = `UP(`NW_BITS),
  localparam int ELEMS      = VLEN / XLEN,
  localparam int MAX_BEATS  = (ELEMS + NUM_THREADS - 1) / NUM_THREADS,
  localparam int VL_W       = ((ELEMS + 1) > 1) ? $clog2(ELEMS + 1) : 1,
  localparam int BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [31:0]                 in_PC,
  input  logic [`NR_BITS-1:0]         in_rd,
  input  logic [VL_W-1:0]             in_vl,
  input  logic [VLEN-1:0]             in_vs1,
  input  logic [VLEN-1:0]             in_vs2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [31:0]                 out_PC,
  output logic [`NR_BITS-1:0]         out_rd,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_rs1_data,
  output logic [NUM_THREADS*XLEN-1:0] out_rs2_data,
  output logic [BEAT_W-1:0]           out_beat,
  output logic                        out_eop
);

  localparam int EL_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                           r_state, w_state_next;
  logic [NW_WIDTH-1:0]              r_wid;
  logic [31:0]                      r_pc;
  logic [`NR_BITS-1:0]              r_rd;
  logic [VL_W-1:0]                  r_vl;
  logic [ELEMS-1:0][XLEN-1:0]       r_vs1, r_vs2;
  logic [BEAT_W-1:0]                r_beat;

  logic                             w_in_fire, w_out_fire, w_last;
  logic [VL_W-1:0]                  w_vl_clamped;
  int                               w_nb, w_e;
  logic [NUM_THREADS-1:0]           w_tmask;
  logic [NUM_THREADS-1:0][XLEN-1:0] w_rs1, w_rs2;

  assign w_vl_clamped = (in_vl > VL_W'(ELEMS)) ? VL_W'(ELEMS) : in_vl;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;

  // vl=0 still issues one (fully masked) beat so the op retires
  always_comb begin
    w_nb = (int'(r_vl) + NUM_THREADS - 1) / NUM_THREADS;
    if (w_nb == 0) w_nb = 1;
  end

  assign w_last = (r_state == S_ISSUE) && (int'(r_beat) == w_nb - 1);

  always_comb begin
    w_tmask = '0;
    w_rs1   = '0;
    w_rs2   = '0;
    w_e     = 0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_e        = int'(r_beat) * NUM_THREADS + t;
      w_tmask[t] = (w_e < int'(r_vl));
      if (w_e < ELEMS) begin
        w_rs1[t] = r_vs1[EL_W'(w_e)];
        w_rs2[t] = r_vs2[EL_W'(w_e)];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_state_next = S_ISSUE;
      S_ISSUE: if (w_out_fire && w_last && !w_in_fire) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wid  <= '0;
      r_pc   <= '0;
      r_rd   <= '0;
      r_vl   <= '0;
      r_vs1  <= '0;
      r_vs2  <= '0;
      r_beat <= '0;
    end else if (w_in_fire) begin
      r_wid  <= in_wid;
      r_pc   <= in_PC;
      r_rd   <= in_rd;
      r_vl   <= w_vl_clamped;
      r_vs1  <= in_vs1;
      r_vs2  <= in_vs2;
      r_beat <= '0;
    end else if (w_out_fire && !w_last) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  assign out_valid    = (r_state == S_ISSUE);
  assign in_ready     = (r_state == S_IDLE) || (w_out_fire && w_last);
  assign out_wid      = r_wid;
  assign out_PC       = r_pc;
  assign out_rd       = r_rd;
  assign out_tmask    = w_tmask;
  assign out_rs1_data = w_rs1;
  assign out_rs2_data = w_rs2;
  assign out_beat     = r_beat;
  assign out_eop      = w_last;

endmodule

// File: tb/tb_vx_vector_slicer.sv
// tb/tb_vx_vector_slicer.sv - table-driven scoreboard bench for vx_vector_slicer
module tb_vx_vector_slicer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [1:0]   in_wid;
  logic [31:0]  in_PC;
  logic [4:0]   in_rd;
  logic [3:0]   in_vl;
  logic [255:0] in_vs1, in_vs2;
  logic         out_valid, out_ready;
  logic [1:0]   out_wid;
  logic [31:0]  out_PC;
  logic [4:0]   out_rd;
  logic [3:0]   out_tmask;
  logic [127:0] out_rs1_data, out_rs2_data;
  logic [0:0]   out_beat;
  logic         out_eop;

  always #5 clk = ~clk;

  vx_vector_slicer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_PC(in_PC), .in_rd(in_rd), .in_vl(in_vl),
    .in_vs1(in_vs1), .in_vs2(in_vs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_PC(out_PC), .out_rd(out_rd),
    .out_tmask(out_tmask), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_beat(out_beat), .out_eop(out_eop)
  );

  typedef struct packed {
    logic [1:0]   wid;
    logic [31:0]  pc;
    logic [4:0]   rd;
    logic [3:0]   tmask;
    logic [0:0]   beat;
    logic         eop;
    logic [127:0] rs1;
    logic [127:0] rs2;
  } beat_t;

  typedef struct {
    logic [3:0]  vl;
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [7:0]  base;
    int          nb;
    logic [3:0]  tm0;
    logic [3:0]  tm1;
  } vec_t;

  beat_t sb[$];
  int    hs_cyc[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    rand_en = 1'b0;
  vec_t  tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] el1(input logic [7:0] base, input int e);
    return {24'h0, base} + 32'(e);
  endfunction

  function automatic logic [31:0] el2(input logic [7:0] base, input int e);
    return 32'hC000_0000 | ({24'h0, base} << 8) | 32'(e);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t act, exp;
    if (!reset && out_valid && out_ready) begin
      act = {out_wid, out_PC, out_rd, out_tmask, out_beat, out_eop, out_rs1_data, out_rs2_data};
      hs_cyc.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got wid=%h pc=%h beat=%0d tm=%b", out_wid, out_PC, out_beat, out_tmask);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL beat: got wid=%h pc=%h rd=%h tm=%b beat=%0d eop=%0b rs1=%h rs2=%h want wid=%h pc=%h rd=%h tm=%b beat=%0d eop=%0b rs1=%h rs2=%h",
                   act.wid, act.pc, act.rd, act.tmask, act.beat, act.eop, act.rs1, act.rs2,
                   exp.wid, exp.pc, exp.rd, exp.tmask, exp.beat, exp.eop, exp.rs1, exp.rs2);
        end
        check("in_ready_at_beat", 128'(in_ready), 128'(exp.eop));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_op(input vec_t v);
    beat_t b;
    bit    ok = 1'b0;
    in_wid = v.wid; in_PC = v.pc; in_rd = v.rd; in_vl = v.vl;
    for (int e = 0; e < 8; e++) begin
      in_vs1[e*32 +: 32] = el1(v.base, e);
      in_vs2[e*32 +: 32] = el2(v.base, e);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int k = 0; k < v.nb; k++) begin
          b.wid = v.wid; b.pc = v.pc; b.rd = v.rd;
          b.tmask = (k == 0) ? v.tm0 : v.tm1;
          b.beat = 1'(k);
          b.eop = (k == v.nb - 1);
          for (int t = 0; t < 4; t++) begin
            b.rs1[t*32 +: 32] = el1(v.base, k*4 + t);
            b.rs2[t*32 +: 32] = el2(v.base, k*4 + t);
          end
          sb.push_back(b);
        end
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 128'(ok), 128'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] exp_rs1;
    int           nvalid;
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_rs1;
    int           nvalid;
    vec_t         va, vb;

    tbl[0] = '{4'd8,  2'd1, 32'h0000_1000, 5'd3,  8'h10, 2, 4'b1111, 4'b1111};
    tbl[1] = '{4'd5,  2'd2, 32'h0000_1004, 5'd7,  8'h20, 2, 4'b1111, 4'b0001};
    tbl[2] = '{4'd3,  2'd3, 32'h0000_1008, 5'd9,  8'h30, 1, 4'b0111, 4'b0000};
    tbl[3] = '{4'd12, 2'd0, 32'h0000_100C, 5'd11, 8'h40, 2, 4'b1111, 4'b1111};
    tbl[4] = '{4'd0,  2'd1, 32'h0000_1010, 5'd13, 8'h50, 1, 4'b0000, 4'b0000};
    tbl[5] = '{4'd4,  2'd2, 32'h0000_1014, 5'd17, 8'h60, 1, 4'b1111, 4'b0000};
    tbl[6] = '{4'd1,  2'd3, 32'h0000_1018, 5'd31, 8'h70, 1, 4'b0001, 4'b0000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_wid = '0; in_PC = '0; in_rd = '0; in_vl = '0; in_vs1 = '0; in_vs2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_eop",   128'(out_eop),   128'(0));
    check("rst_tmask",     128'(out_tmask), 128'(0));
    check("rst_rs1",       out_rs1_data,    128'(0));
    check("rst_beat",      128'(out_beat),  128'(0));
    @(posedge clk); #1;

    foreach (tbl[i]) send_op(tbl[i]);
    drain();

    rand_en = 1'b1;
    foreach (tbl[i]) send_op(tbl[i]);
    drain();
    rand_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // beat0 must hold while the consumer stalls
    out_ready = 1'b0;
    send_op(tbl[3]);
    for (int t = 0; t < 4; t++) exp_rs1[t*32 +: 32] = el1(8'h40, t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {out_valid, out_beat, out_eop, out_tmask, out_wid, out_PC, out_rs1_data[85:0]},
            {1'b1, 1'b0, 1'b0, 4'b1111, 2'd0, 32'h0000_100C, exp_rs1[85:0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    hs_cyc.delete();
    va = tbl[0];
    vb = tbl[3]; vb.wid = 2'd2; vb.pc = 32'hBEEF_0040;
    send_op(va);
    send_op(vb);
    drain();
    check("b2b_beats", 128'(hs_cyc.size()), 128'(4));
    if (hs_cyc.size() == 4) check("b2b_no_bubble", 128'(hs_cyc[3] - hs_cyc[0]), 128'(3));

    send_op(tbl[0]);
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid",  128'(out_valid), 128'(0));
    check("rst_mid_ready",  128'(in_ready),  128'(1));
    check("rst_mid_left",   128'(sb.size()), 128'(1));
    sb.delete();
    out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("rst_mid_no_beat1", 128'(nvalid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
